// File: rtl/yuv422_to_yuv444.sv
// 4-pixel/clock 4:2:2 -> 4:4:4 chroma upsampler with one-beat lookahead for odd-pixel chroma.
// Two-stage pipeline: stage-1 beat register, then output register; syncs and data delayed 2 clocks.
module yuv422_to_yuv444 #(
   parameter int INTERP     = 1,
   parameter int BLANK_ZERO = 1,
   parameter int CNT_W      = 12
) (
   input  logic             vid_clk,
   input  logic             vid_rst_n,
   input  logic [31:0]      in_y,
   input  logic [31:0]      in_c,
   input  logic             in_hs,
   input  logic             in_vs,
   input  logic             in_de,
   output logic [31:0]      out_y,
   output logic [31:0]      out_u,
   output logic [31:0]      out_v,
   output logic             out_hs,
   output logic             out_vs,
   output logic             out_de,
   output logic [CNT_W-1:0] line_beats
);

   logic [31:0]      s1_y;
   logic [31:0]      s1_c;
   logic             s1_hs;
   logic             s1_vs;
   logic             s1_de;
   logic [31:0]      u_nxt;
   logic [31:0]      v_nxt;
   logic [CNT_W-1:0] beat_cnt;

   function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b} + 9'd1;
      return sum[8:1];
   endfunction

   always_ff @(posedge vid_clk or negedge vid_rst_n) begin
      if (!vid_rst_n) begin
         s1_y  <= '0;
         s1_c  <= '0;
         s1_hs <= 1'b0;
         s1_vs <= 1'b0;
         s1_de <= 1'b0;
      end else begin
         s1_y  <= in_y;
         s1_c  <= in_c;
         s1_hs <= in_hs;
         s1_vs <= in_vs;
         s1_de <= in_de;
      end
   end

   // Live input is the next beat; its co-sited p0 chroma feeds p3 of the current beat.
   always_comb begin
      u_nxt = '0;
      v_nxt = '0;
      u_nxt[7:0]   = s1_c[7:0];
      v_nxt[7:0]   = s1_c[15:8];
      u_nxt[23:16] = s1_c[23:16];
      v_nxt[23:16] = s1_c[31:24];
      if (INTERP != 0) begin
         u_nxt[15:8] = avg8(s1_c[7:0], s1_c[23:16]);
         v_nxt[15:8] = avg8(s1_c[15:8], s1_c[31:24]);
         if (in_de) begin
            u_nxt[31:24] = avg8(s1_c[23:16], in_c[7:0]);
            v_nxt[31:24] = avg8(s1_c[31:24], in_c[15:8]);
         end else begin
            u_nxt[31:24] = s1_c[23:16];
            v_nxt[31:24] = s1_c[31:24];
         end
      end else begin
         u_nxt[15:8]  = s1_c[7:0];
         v_nxt[15:8]  = s1_c[15:8];
         u_nxt[31:24] = s1_c[23:16];
         v_nxt[31:24] = s1_c[31:24];
      end
   end

   always_ff @(posedge vid_clk or negedge vid_rst_n) begin
      if (!vid_rst_n) begin
         out_y  <= '0;
         out_u  <= '0;
         out_v  <= '0;
         out_hs <= 1'b0;
         out_vs <= 1'b0;
         out_de <= 1'b0;
      end else begin
         out_hs <= s1_hs;
         out_vs <= s1_vs;
         out_de <= s1_de;
         if ((BLANK_ZERO != 0) && !s1_de) begin
            out_y <= '0;
            out_u <= '0;
            out_v <= '0;
         end else begin
            out_y <= s1_y;
            out_u <= u_nxt;
            out_v <= v_nxt;
         end
      end
   end

   // out_de holds the previous stage-1 de, so (!s1_de && out_de) marks the line's end.
   always_ff @(posedge vid_clk or negedge vid_rst_n) begin
      if (!vid_rst_n) begin
         beat_cnt   <= '0;
         line_beats <= '0;
      end else if (s1_de) begin
         if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
      end else if (out_de) begin
         line_beats <= beat_cnt;
         beat_cnt   <= '0;
      end
   end

endmodule

// File: tb/tb_yuv422_to_yuv444.sv
// Self-checking bench for yuv422_to_yuv444: default instance plus an INTERP=0 instance on shared inputs.
module tb_yuv422_to_yuv444;

   logic        vid_clk = 1'b0;
   logic        vid_rst_n;
   logic [31:0] in_y, in_c;
   logic        in_hs, in_vs, in_de;

   logic [31:0] a_y, a_u, a_v, b_y, b_u, b_v;
   logic        a_hs, a_vs, a_de, b_hs, b_vs, b_de;
   logic [11:0] a_lb, b_lb;

   yuv422_to_yuv444 dut (
      .vid_clk(vid_clk), .vid_rst_n(vid_rst_n),
      .in_y(in_y), .in_c(in_c), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
      .out_y(a_y), .out_u(a_u), .out_v(a_v),
      .out_hs(a_hs), .out_vs(a_vs), .out_de(a_de), .line_beats(a_lb)
   );

   yuv422_to_yuv444 #(.INTERP(0)) dut_ni (
      .vid_clk(vid_clk), .vid_rst_n(vid_rst_n),
      .in_y(in_y), .in_c(in_c), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
      .out_y(b_y), .out_u(b_u), .out_v(b_v),
      .out_hs(b_hs), .out_vs(b_vs), .out_de(b_de), .line_beats(b_lb)
   );

   always #5 vid_clk = ~vid_clk;

   typedef struct {
      logic [31:0] y, u1, v1, u0, v0;
      logic [2:0]  sync;
      logic [11:0] lb;
   } exp_t;

   typedef struct {
      logic [31:0] y_a, c_a, c_b;
      logic        de_b;
      logic [31:0] u1, v1, u0, v0;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[5];
   int   total = 0;
   int   bad   = 0;

   logic [31:0] prev_y, prev_c;
   logic        prev_hs, prev_vs, prev_de, pp_de;
   int          m_cnt, m_lb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mavg(input logic [7:0] a, input logic [7:0] b);
      int s;
      s = (int'(a) + int'(b) + 1) / 2;
      return s[7:0];
   endfunction

   function automatic logic [31:0] mchroma(input logic [31:0] c, input logic [31:0] nc,
                                           input logic nde, input bit interp, input bit is_v);
      logic [7:0] lo, hi, nlo, p1, p3;
      lo  = is_v ? c[15:8]  : c[7:0];
      hi  = is_v ? c[31:24] : c[23:16];
      nlo = is_v ? nc[15:8] : nc[7:0];
      if (interp) begin
         p1 = mavg(lo, hi);
         p3 = nde ? mavg(hi, nlo) : hi;
      end else begin
         p1 = lo;
         p3 = hi;
      end
      return {p3, hi, p1, lo};
   endfunction

   task automatic model_reset();
      sbq.delete();
      prev_y = '0; prev_c = '0; prev_hs = 0; prev_vs = 0; prev_de = 0; pp_de = 0;
      m_cnt = 0; m_lb = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_y"}, a_y, 32'h0);
      chk({tag, "_u"}, a_u, 32'h0);
      chk({tag, "_v"}, a_v, 32'h0);
      chk({tag, "_sync"}, {29'h0, a_hs, a_vs, a_de}, 32'h0);
      chk({tag, "_lb"}, {20'h0, a_lb}, 32'h0);
      chk({tag, "_ni_u"}, b_u, 32'h0);
      chk({tag, "_ni_sync"}, {29'h0, b_hs, b_vs, b_de}, 32'h0);
   endtask

   // Called at a falling edge: check the beat due now, drive the next, queue its predecessor's result.
   task automatic step(input logic [31:0] y, input logic [31:0] c,
                       input logic hs, input logic vs, input logic de);
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("sb_y", a_y, e.y);
         chk("sb_u", a_u, e.u1);
         chk("sb_v", a_v, e.v1);
         chk("sb_ni_y", b_y, e.y);
         chk("sb_ni_u", b_u, e.u0);
         chk("sb_ni_v", b_v, e.v0);
         chk("sb_sync", {29'h0, a_hs, a_vs, a_de}, {29'h0, e.sync});
         chk("sb_ni_sync", {29'h0, b_hs, b_vs, b_de}, {29'h0, e.sync});
         chk("sb_lb", {20'h0, a_lb}, {20'h0, e.lb});
         chk("sb_ni_lb", {20'h0, b_lb}, {20'h0, e.lb});
      end
      in_y = y; in_c = c; in_hs = hs; in_vs = vs; in_de = de;
      if (prev_de) begin
         if (m_cnt != 4095) m_cnt++;
      end else if (pp_de) begin
         m_lb  = m_cnt;
         m_cnt = 0;
      end
      e.sync = {prev_hs, prev_vs, prev_de};
      e.lb   = m_lb[11:0];
      if (prev_de) begin
         e.y  = prev_y;
         e.u1 = mchroma(prev_c, c, de, 1'b1, 1'b0);
         e.v1 = mchroma(prev_c, c, de, 1'b1, 1'b1);
         e.u0 = mchroma(prev_c, c, de, 1'b0, 1'b0);
         e.v0 = mchroma(prev_c, c, de, 1'b0, 1'b1);
      end else begin
         e.y = '0; e.u1 = '0; e.v1 = '0; e.u0 = '0; e.v0 = '0;
      end
      sbq.push_back(e);
      pp_de = prev_de;
      prev_y = y; prev_c = c; prev_hs = hs; prev_vs = vs; prev_de = de;
      @(negedge vid_clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vecs[0] = '{32'h11223344, 32'hA0608040, 32'h00002081, 1'b1,
                  32'h71605040, 32'h60A09080, 32'h60604040, 32'hA0A08080};
      vecs[1] = '{32'hCAFEF00D, 32'hA0608040, 32'h12345678, 1'b0,
                  32'h60605040, 32'hA0A09080, 32'h60604040, 32'hA0A08080};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[3] = '{32'h01020304, 32'h00000000, 32'h00000001, 1'b1,
                  32'h01000000, 32'h00000000, 32'h00000000, 32'h00000000};
      vecs[4] = '{32'h80808080, 32'h10203040, 32'h0000FF01, 1'b1,
                  32'h11203040, 32'h88102030, 32'h20204040, 32'h10103030};

      vid_rst_n = 1'b0;
      in_y = '0; in_c = '0; in_hs = 0; in_vs = 0; in_de = 0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge vid_clk);
         in_y = $urandom; in_c = $urandom;
         in_hs = 1'($urandom); in_vs = 1'($urandom); in_de = 1'($urandom);
         #1 chk_zero("rst");
      end
      @(negedge vid_clk);
      vid_rst_n = 1'b1;

      // first de beat appears on out_de exactly two clocks later
      step(32'h0A0B0C0D, 32'h44332211, 1'b0, 1'b0, 1'b1);
      chk("lat_de_1clk", {31'h0, a_de}, 32'h0);
      step('0, '0, 1'b0, 1'b0, 1'b0);
      chk("lat_de_2clk", {31'h0, a_de}, 32'h1);
      chk("lat_y", a_y, 32'h0A0B0C0D);
      idle(3);

      foreach (vecs[i]) begin
         step(vecs[i].y_a, vecs[i].c_a, 1'b0, 1'b0, 1'b1);
         step(32'h5555AAAA, vecs[i].c_b, 1'b0, 1'b0, vecs[i].de_b);
         chk("vec_y", a_y, vecs[i].y_a);
         chk("vec_u", a_u, vecs[i].u1);
         chk("vec_v", a_v, vecs[i].v1);
         chk("vec_ni_u", b_u, vecs[i].u0);
         chk("vec_ni_v", b_v, vecs[i].v0);
         idle(3);
      end

      idle(2);
      step(32'h12121212, 32'h9F8E7D6C, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("single_lb", {20'h0, a_lb}, 32'd1);

      for (int i = 0; i < 4; i++) step('0, '0, 1'b1, 1'b1, 1'b0);
      idle(4);
      for (int i = 0; i < 480; i++) step($urandom, $urandom, 1'b0, 1'b0, 1'b1);
      step('0, '0, 1'b1, 1'b0, 1'b0);
      step('0, '0, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("line480_lb", {20'h0, a_lb}, 32'd480);
      chk("line480_ni_lb", {20'h0, b_lb}, 32'd480);

      for (int i = 0; i < 100; i++) step($urandom, $urandom, 1'b0, 1'b0, 1'b1);
      vid_rst_n = 1'b0;
      #1 chk_zero("midrst");
      @(negedge vid_clk);
      @(negedge vid_clk);
      model_reset();
      vid_rst_n = 1'b1;
      for (int i = 0; i < 7; i++) step($urandom, $urandom, 1'b0, 1'b0, 1'b1);
      idle(4);
      chk("midrst_lb", {20'h0, a_lb}, 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
